// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester round-robin burst arbiter with registered output beat
//
// Purpose: grants one of two valid/ready requesters at a time, forwards up to
// MAX_BURST beats per grant into a single registered output slot, then
// re-arbitrates without an idle bubble.
//
// Ports:
//    clk_i, rst_ni           clock, synchronous active-low reset
//    a_valid_i/a_data_i      requester A beat offer; a_ready_o accepts it
//    b_valid_i/b_data_i      requester B beat offer; b_ready_o accepts it
//    o_valid_o/o_data_o      registered output beat; o_ready_i accepts it
//    sel_o                   1 while A is granted
//    grant_o                 one-hot grant, bit0 = A, bit1 = B
module mux2_arbiter #(
   parameter int DATA_WIDTH = 20,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  a_valid_i,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   output logic                  a_ready_o,
   input  logic                  b_valid_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   output logic                  b_ready_o,
   output logic                  o_valid_o,
   output logic [DATA_WIDTH-1:0] o_data_o,
   input  logic                  o_ready_i,
   output logic                  sel_o,
   output logic [1:0]            grant_o
);

   localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  last_a_q, last_a_d;   // 1 = A was granted last, 0 = B
   logic [7:0]            cnt_q, cnt_d;
   logic                  o_valid_q, o_valid_d;
   logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

   logic                  slot_free;
   logic                  a_acc, b_acc, beat_acc;
   logic                  cnt_hit;
   logic [DATA_WIDTH-1:0] beat_data;

   // The output slot can take a new beat when empty or draining this cycle.
   assign slot_free = !o_valid_q || o_ready_i;
   assign a_acc     = a_valid_i && a_ready_o;
   assign b_acc     = b_valid_i && b_ready_o;
   assign beat_acc  = a_acc || b_acc;
   assign beat_data = a_acc ? a_data_i : b_data_i;
   assign cnt_hit   = (cnt_q + 8'd1) == MAX_BURST_C;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         last_a_q  <= 1'b0;
         cnt_q     <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_a_q  <= last_a_d;
         cnt_q     <= cnt_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      last_a_d = last_a_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (a_valid_i && b_valid_i) begin
               state_d = last_a_q ? GRANT_B : GRANT_A;
            end else if (a_valid_i) begin
               state_d = GRANT_A;
            end else if (b_valid_i) begin
               state_d = GRANT_B;
            end
         end
         GRANT_A: begin
            // Release on burst exhaustion or when A stops offering beats.
            if (!a_valid_i || (a_acc && cnt_hit)) begin
               last_a_d = 1'b1;
               cnt_d    = '0;
               if (b_valid_i)      state_d = GRANT_B;
               else if (a_valid_i) state_d = GRANT_A;
               else                state_d = IDLE;
            end else if (a_acc) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         GRANT_B: begin
            if (!b_valid_i || (b_acc && cnt_hit)) begin
               last_a_d = 1'b0;
               cnt_d    = '0;
               if (a_valid_i)      state_d = GRANT_A;
               else if (b_valid_i) state_d = GRANT_B;
               else                state_d = IDLE;
            end else if (b_acc) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode; readies are held low while reset is asserted so no
   // requester believes a beat was taken on the reset edge.
   always_comb begin
      a_ready_o = 1'b0;
      b_ready_o = 1'b0;
      grant_o   = 2'b00;
      sel_o     = 1'b0;
      case (state_q)
         GRANT_A: begin
            grant_o   = 2'b01;
            sel_o     = 1'b1;
            a_ready_o = rst_ni && slot_free;
         end
         GRANT_B: begin
            grant_o   = 2'b10;
            b_ready_o = rst_ni && slot_free;
         end
         default: ;
      endcase
   end

   // Output slot: load on accept, clear on drain, otherwise hold.
   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      if (beat_acc) begin
         o_valid_d = 1'b1;
         o_data_d  = beat_data;
      end else if (o_ready_i) begin
         o_valid_d = 1'b0;
      end
   end

   assign o_valid_o = o_valid_q;
   assign o_data_o  = o_data_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - self-checking bench for mux2_arbiter
module tb_mux2_arbiter;

   localparam int DW = 20;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          a_valid_i = 1'b0, b_valid_i = 1'b0, o_ready_i = 1'b0;
   logic [DW-1:0] a_data_i = '0, b_data_i = '0;
   logic          use1 = 1'b0;

   logic          a_ready_4, b_ready_4, o_valid_4, sel_4;
   logic [DW-1:0] o_data_4;
   logic [1:0]    grant_4;
   logic          a_ready_1, b_ready_1, o_valid_1, sel_1;
   logic [DW-1:0] o_data_1;
   logic [1:0]    grant_1;

   logic          a_ready, b_ready, o_valid, sel;
   logic [DW-1:0] o_data;
   logic [1:0]    grant;

   always #5 clk = ~clk;

   mux2_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_4),
      .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_4),
      .o_valid_o(o_valid_4), .o_data_o(o_data_4), .o_ready_i(o_ready_i),
      .sel_o(sel_4), .grant_o(grant_4));

   mux2_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_1),
      .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_1),
      .o_valid_o(o_valid_1), .o_data_o(o_data_1), .o_ready_i(o_ready_i),
      .sel_o(sel_1), .grant_o(grant_1));

   assign a_ready = use1 ? a_ready_1 : a_ready_4;
   assign b_ready = use1 ? b_ready_1 : b_ready_4;
   assign o_valid = use1 ? o_valid_1 : o_valid_4;
   assign o_data  = use1 ? o_data_1  : o_data_4;
   assign sel     = use1 ? sel_1     : sel_4;
   assign grant   = use1 ? grant_1   : grant_4;

   typedef struct {
      bit       a_v;
      bit       b_v;
      bit [1:0] g;
      bit       ar;
      bit       br;
      bit       s;
   } vec_t;
   vec_t tbl[4];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int first_x = -1;
   int last_x = -1;
   bit a_en = 0, b_en = 0, chk_sel = 0;
   bit a_rdy_s = 0, b_rdy_s = 0;
   logic [DW-1:0] a_src[$], b_src[$], exp_q[$];
   bit exp_sel_q[$];

   function automatic logic [DW-1:0] av(int i);
      return DW'(i);
   endfunction
   function automatic logic [DW-1:0] bv(int i);
      return DW'(32'h10000 + i);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      a_valid_i = a_en && (a_src.size() != 0);
      a_data_i  = a_valid_i ? a_src[0] : '0;
      b_valid_i = b_en && (b_src.size() != 0);
      b_data_i  = b_valid_i ? b_src[0] : '0;
   endtask

   // One clock: sample handshakes and output transfers at the negedge,
   // then advance the sources after the rising edge.
   task automatic step();
      bit ha, hb;
      @(negedge clk);
      ha = a_valid_i && a_ready;
      hb = b_valid_i && b_ready;
      a_rdy_s = a_ready;
      b_rdy_s = b_ready;
      if (o_valid && o_ready_i) begin
         if (exp_q.size() == 0) check("unexpected_beat", 32'(o_data), 32'hFFFFFFFF);
         else check("o_data", 32'(o_data), 32'(exp_q.pop_front()));
         if (first_x < 0) first_x = cyc;
         last_x = cyc;
      end
      if (chk_sel && (ha || hb)) begin
         if (exp_sel_q.size() == 0) check("sel_extra", 32'(sel), 32'h2);
         else check("sel_per_beat", 32'(sel), 32'(exp_sel_q.pop_front()));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (ha) void'(a_src.pop_front());
      if (hb) void'(b_src.pop_front());
      if (ha || hb) acc_cnt++;
      drive();
   endtask

   task automatic run_until_empty(int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_complete", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      a_en = 0;
      b_en = 0;
      a_src.delete();
      b_src.delete();
      exp_q.delete();
      exp_sel_q.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      acc_cnt = 0;
      first_x = -1;
   endtask

   task automatic load_src(int n);
      a_src.delete();
      b_src.delete();
      for (int i = 1; i <= n; i++) begin
         a_src.push_back(av(i));
         b_src.push_back(bv(i));
      end
   endtask

   task automatic exp_burst4();
      exp_q.delete();
      for (int blk = 0; blk < 2; blk++) begin
         for (int k = 1; k <= 4; k++) exp_q.push_back(av(blk * 4 + k));
         for (int k = 1; k <= 4; k++) exp_q.push_back(bv(blk * 4 + k));
      end
   endtask

   initial begin
      // IDLE arbitration right after reset: A wins the first tie.
      tbl[0] = '{a_v: 0, b_v: 0, g: 2'b00, ar: 0, br: 0, s: 0};
      tbl[1] = '{a_v: 1, b_v: 0, g: 2'b01, ar: 1, br: 0, s: 1};
      tbl[2] = '{a_v: 0, b_v: 1, g: 2'b10, ar: 0, br: 1, s: 0};
      tbl[3] = '{a_v: 1, b_v: 1, g: 2'b01, ar: 1, br: 0, s: 1};

      use1 = 1'b0;
      o_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rst_ni = 1'b0;
         a_valid_i = 1'b0;
         b_valid_i = 1'b0;
         @(posedge clk);
         #1;
         rst_ni = 1'b1;
         a_valid_i = tbl[i].a_v;
         b_valid_i = tbl[i].b_v;
         a_data_i = av(1);
         b_data_i = bv(1);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
         check($sformatf("tbl%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ar));
         check($sformatf("tbl%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].br));
         check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].s));
      end

      // Reset with both valid held, then the full MAX_BURST=4 interleave.
      do_reset();
      o_ready_i = 1'b1;
      rst_ni = 1'b0;
      load_src(8);
      exp_burst4();
      a_en = 1;
      b_en = 1;
      drive();
      step();
      step();
      check("rst_a_ready", 32'(a_rdy_s), 32'd0);
      check("rst_b_ready", 32'(b_rdy_s), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_data", 32'(o_data), 32'd0);
      rst_ni = 1'b1;
      first_x = -1;
      step();
      check("post_rst_grant", 32'(grant), 32'b01);
      check("post_rst_o_valid", 32'(o_valid), 32'd0);
      step();
      check("first_beat_valid", 32'(o_valid), 32'd1);
      check("first_beat_data", 32'(o_data), 32'(av(1)));
      run_until_empty(60);
      check("no_idle_between_bursts", 32'(last_x - first_x), 32'd15);

      // Only B valid for two beats, then round-robin after each side.
      do_reset();
      o_ready_i = 1'b1;
      b_src.push_back(bv(1));
      b_src.push_back(bv(2));
      exp_q.push_back(bv(1));
      exp_q.push_back(bv(2));
      b_en = 1;
      drive();
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("b_only_grant%0d", k), 32'(grant), 32'b10);
      end
      step();
      check("b_drop_idle", 32'(grant), 32'b00);
      check("b_only_drained", 32'(exp_q.size()), 32'd0);
      a_src.push_back(av(1));
      b_src.push_back(bv(3));
      exp_q.push_back(av(1));
      exp_q.push_back(bv(3));
      a_en = 1;
      drive();
      step();
      check("tie_after_b", 32'(grant), 32'b01);
      run_until_empty(20);
      b_en = 0;
      a_src.push_back(av(2));
      exp_q.push_back(av(2));
      drive();
      run_until_empty(20);
      step();
      check("a_only_idle", 32'(grant), 32'b00);
      a_src.push_back(av(3));
      b_src.push_back(bv(4));
      exp_q.push_back(bv(4));
      exp_q.push_back(av(3));
      b_en = 1;
      drive();
      step();
      check("tie_after_a", 32'(grant), 32'b10);
      run_until_empty(20);

      // Downstream stall for five cycles in the middle of an A burst.
      do_reset();
      o_ready_i = 1'b1;
      load_src(8);
      exp_burst4();
      a_en = 1;
      b_en = 1;
      drive();
      for (int n = 0; n < 20 && acc_cnt < 2; n++) step();
      check("stall_setup", 32'(acc_cnt), 32'd2);
      o_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("stall%0d_o_valid", k), 32'(o_valid), 32'd1);
         check($sformatf("stall%0d_o_data", k), 32'(o_data), 32'(av(2)));
         check($sformatf("stall%0d_a_ready", k), 32'(a_rdy_s), 32'd0);
         check($sformatf("stall%0d_grant", k), 32'(grant), 32'b01);
      end
      check("stall_no_accept", 32'(acc_cnt), 32'd2);
      o_ready_i = 1'b1;
      run_until_empty(60);

      // MAX_BURST=1: grant alternates every accepted beat.
      use1 = 1'b1;
      do_reset();
      o_ready_i = 1'b1;
      load_src(4);
      exp_q.delete();
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(av(k));
         exp_q.push_back(bv(k));
         exp_sel_q.push_back(1'b1);
         exp_sel_q.push_back(1'b0);
      end
      chk_sel = 1;
      a_en = 1;
      b_en = 1;
      drive();
      run_until_empty(40);
      chk_sel = 0;
      check("mb1_sel_all_seen", 32'(exp_sel_q.size()), 32'd0);
      use1 = 1'b0;

      // Reset pulse at beat 2 of an A burst abandons it; A wins again.
      do_reset();
      o_ready_i = 1'b1;
      load_src(8);
      exp_burst4();
      a_en = 1;
      b_en = 1;
      drive();
      for (int n = 0; n < 20 && acc_cnt < 2; n++) step();
      check("rst_mid_setup", 32'(acc_cnt), 32'd2);
      rst_ni = 1'b0;
      step();
      check("rst_mid_o_valid", 32'(o_valid), 32'd0);
      check("rst_mid_grant", 32'(grant), 32'b00);
      check("rst_mid_no_accept", 32'(acc_cnt), 32'd2);
      rst_ni = 1'b1;
      load_src(8);
      exp_burst4();
      drive();
      step();
      check("rst_mid_restart_grant", 32'(grant), 32'b01);
      run_until_empty(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, width of all data ports.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..255.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports a_valid_i / a_data_i, input, 1 / DATA_WIDTH, requester A beat offer.
REQ-006 SHALL have port a_ready_o, output, 1, requester A beat accepted when a_valid_i && a_ready_o.
REQ-007 SHALL have ports b_valid_i / b_data_i / b_ready_o, the same as A, for requester B.
REQ-008 SHALL have ports o_valid_o / o_data_o, output, 1 / DATA_WIDTH, registered output beat.
REQ-009 SHALL have port o_ready_i, input, 1, downstream accept; a transfer occurs when o_valid_o && o_ready_i.
REQ-010 SHALL have port sel_o, output, 1, mux select: 1 = A granted, 0 otherwise.
REQ-011 SHALL have port grant_o, output, 2, one-hot grant; bit0 = A, bit1 = B, 00 = none.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT_A, GRANT_B; grant_o and sel_o decode the state only.
REQ-013 SHALL keep a last_grant flag; in IDLE, when both requesters are valid, it SHALL grant the requester that was not last granted (round-robin).
REQ-014 SHALL, in IDLE with only one requester valid, move to that requester's GRANT state on the next edge.
REQ-015 SHALL drive x_ready_o = (state == GRANT_x) && (!o_valid_o || o_ready_i); the non-granted ready SHALL be 0.
REQ-016 SHALL, on an accepted beat, register o_data_o <= x_data_i and o_valid_o <= 1 on the same edge.
REQ-017 SHALL, when a downstream transfer occurs with no new beat accepted, clear o_valid_o; o_data_o SHALL hold its last value.
REQ-018 SHALL keep o_valid_o/o_data_o stable while o_valid_o && !o_ready_i.
REQ-019 Latency: valid raised in IDLE at cycle n -> grant in n+1 -> accept in n+1 if the output slot is free -> o_valid_o in n+2.
REQ-020 SHALL keep a beat counter: cleared on grant entry, incremented per accepted beat.
REQ-021 Release condition SHALL be either (a) an accepted beat making the count equal MAX_BURST, or (b) x_valid_i == 0 while in GRANT_x.
REQ-022 On release, SHALL set last_grant = x, then move as follows:
  - other requester valid -> GRANT_other on the next edge, counter cleared, no IDLE bubble;
  - else x still valid (burst exhausted) -> re-enter GRANT_x, counter cleared;
  - else -> IDLE.
REQ-023 SHALL NOT let a requester dropping valid mid-grant with no accepted beat corrupt the output register.
REQ-024 SHALL, with MAX_BURST = 1, alternate grants every beat when both requesters are continuously valid.
REQ-025 Downstream stall SHALL NOT advance the counter or force release; the grant is held until release per REQ-021.
REQ-026 A beat already in the output register SHALL still drain normally after a grant switch.

Reset
REQ-027 SHALL, while rst_ni == 0 at a clock edge, set:
  - state = IDLE, last_grant = B (so A wins the first tie);
  - counter = 0, o_valid_o = 0, o_data_o = 0.
REQ-028 SHALL give, during and after reset: a_ready_o = b_ready_o = 0, grant_o = 00, sel_o = 0.
REQ-029 SHALL treat reset asserted mid-burst as abandoning the burst; any un-transferred output beat is discarded.

Verification
REQ-030 Reset with a_valid_i = b_valid_i = 1 held -> all outputs 0; first edge after release gives grant_o = 01; o_valid_o = 1 one edge later.
REQ-031 MAX_BURST = 4, both valid, o_ready_i = 1, A data 0x00001..0x00008, B data 0x10001..0x10008 -> output A1..A4, B1..B4, A5..A8, B5..B8 with no idle cycles between bursts.
REQ-032 Only B valid for 2 beats, then B drops -> grant_o = 10 for those beats, then 00; last_grant = B; next tie grants A.
REQ-033 o_ready_i = 0 for 5 cycles while granted -> o_valid_o/o_data_o stable, ready 0, counter frozen; beats resume on o_ready_i = 1 with none lost or duplicated.
REQ-034 MAX_BURST = 1, both valid -> sel_o toggles 1,0,1,0 per accepted beat.
REQ-035 rst_ni pulsed low at beat 2 of an A burst -> o_valid_o = 0 and grant_o = 00 the next cycle; arbitration restarts with A.
